// File: rtl/macc_matrix_buf.sv
// Multi-channel matrix operand buffer: each channel is an independent FIFO that
// can also replay its contents in a loop without consuming them.
module macc_matrix_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int NUM_CH = 3
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic [NUM_CH-1:0]                    wen,
    input  logic [NUM_CH-1:0]                    ren,
    input  logic [NUM_CH-1:0]                    replay,
    input  logic [NUM_CH-1:0]                    rewind,
    input  logic [NUM_CH-1:0]                    clr,
    input  logic [NUM_CH*DATA_W-1:0]             data_in,
    output logic [NUM_CH*DATA_W-1:0]             data_out,
    output logic [NUM_CH-1:0]                    full,
    output logic [NUM_CH-1:0]                    empty,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]  count,
    output logic [NUM_CH-1:0]                    ovf,
    output logic [NUM_CH-1:0]                    unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [NUM_CH-1:0][AW-1:0] head_q, head_d;
    logic [NUM_CH-1:0][AW-1:0] wptr_q, wptr_d;
    logic [NUM_CH-1:0][AW-1:0] roff_q, roff_d;
    logic [NUM_CH-1:0][CW-1:0] count_q, count_d;
    logic [NUM_CH-1:0]         ovf_q, ovf_d;
    logic [NUM_CH-1:0]         unf_q, unf_d;
    logic [NUM_CH-1:0]         push, pop, isEmpty, isFull;
    logic [NUM_CH-1:0][AW-1:0] rdIdx;
    logic [DATA_W-1:0]         mem_q [NUM_CH][DEPTH];

    always_comb begin
        isEmpty  = '0;
        isFull   = '0;
        rdIdx    = '0;
        data_out = '0;
        count    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            isEmpty[k] = (count_q[k] == '0);
            isFull[k]  = (count_q[k] == CW'(DEPTH));
            rdIdx[k]   = head_q[k] + roff_q[k];
            data_out[k*DATA_W +: DATA_W] = isEmpty[k] ? '0 : mem_q[k][rdIdx[k]];
            count[k*CW +: CW] = count_q[k];
        end
    end

    assign empty = isEmpty;
    assign full  = isFull;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

    // A FIFO pop frees a slot in the same cycle, so a write at full still lands.
    always_comb begin
        push    = '0;
        pop     = '0;
        head_d  = head_q;
        wptr_d  = wptr_q;
        roff_d  = roff_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        for (int k = 0; k < NUM_CH; k++) begin
            pop[k]  = ren[k] & ~isEmpty[k] & ~replay[k] & ~clr[k];
            push[k] = wen[k] & (~isFull[k] | pop[k]) & ~clr[k];
            if (clr[k]) begin
                head_d[k]  = '0;
                wptr_d[k]  = '0;
                roff_d[k]  = '0;
                count_d[k] = '0;
                ovf_d[k]   = 1'b0;
                unf_d[k]   = 1'b0;
            end else begin
                if (push[k])
                    wptr_d[k] = wptr_q[k] + AW'(1);
                if (pop[k])
                    head_d[k] = head_q[k] + AW'(1);
                if (push[k] && !pop[k])
                    count_d[k] = count_q[k] + CW'(1);
                else if (pop[k] && !push[k])
                    count_d[k] = count_q[k] - CW'(1);
                if (wen[k] && isFull[k] && !pop[k])
                    ovf_d[k] = 1'b1;
                if (ren[k] && isEmpty[k])
                    unf_d[k] = 1'b1;
                if (!replay[k] || rewind[k])
                    roff_d[k] = '0;
                else if (ren[k] && !isEmpty[k])
                    roff_d[k] = ({1'b0, roff_q[k]} == count_q[k] - CW'(1)) ? '0 : roff_q[k] + AW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_q  <= '0;
            wptr_q  <= '0;
            roff_q  <= '0;
            count_q <= '0;
            ovf_q   <= '0;
            unf_q   <= '0;
        end else begin
            head_q  <= head_d;
            wptr_q  <= wptr_d;
            roff_q  <= roff_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is deliberately left out of reset; count gates what is visible.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (push[k])
                mem_q[k][wptr_q[k]] <= data_in[k*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_macc_matrix_buf.sv
// Directed bench for macc_matrix_buf: FIFO order, full/wrap, replay, flags,
// channel independence and asynchronous reset.
module tb_macc_matrix_buf;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int NUM_CH = 3;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic                     CLK;
    logic                     RST;
    logic [NUM_CH-1:0]        wen, ren, replay, rewind, clr;
    logic [NUM_CH*DATA_W-1:0] data_in;
    logic [NUM_CH*DATA_W-1:0] data_out;
    logic [NUM_CH-1:0]        full, empty, ovf, unf;
    logic [NUM_CH*CW-1:0]     count;

    int errors = 0;
    int checks = 0;

    macc_matrix_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
        .CLK(CLK), .RST(RST), .wen(wen), .ren(ren), .replay(replay),
        .rewind(rewind), .clr(clr), .data_in(data_in), .data_out(data_out),
        .full(full), .empty(empty), .count(count), .ovf(ovf), .unf(unf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [DATA_W-1:0] doutOf(input int ch);
        return data_out[ch*DATA_W +: DATA_W];
    endfunction

    function automatic logic [CW-1:0] countOf(input int ch);
        return count[ch*CW +: CW];
    endfunction

    // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        wen = '0; ren = '0; rewind = '0; clr = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1; wen = '1; ren = '1; replay = '0; rewind = '0; clr = '0;
        data_in = {NUM_CH{32'h12345678}};
        repeat (5) tick();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checks++;
            if (countOf(ch) !== CW'(0) || empty[ch] !== 1'b1 || full[ch] !== 1'b0 ||
                doutOf(ch) !== 32'h0 || ovf[ch] !== 1'b0 || unf[ch] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset ch%0d: count=%0d empty=%b full=%b dout=%h ovf=%b unf=%b, required 0 1 0 0 0 0",
                         ch, countOf(ch), empty[ch], full[ch], doutOf(ch), ovf[ch], unf[ch]);
            end
        end
        idle();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_fifo_order();
        logic [DATA_W-1:0] expPop [3];
        expPop[0] = 32'hFEED2B0B; expPop[1] = 32'h00000001; expPop[2] = 32'h0;
        wen[0] = 1'b1; data_in[31:0] = 32'hDEADBEEF; tick();
        checks++;
        if (doutOf(0) !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL fifo_first_show: got %h, required DEADBEEF", doutOf(0));
        end
        wen[0] = 1'b0; data_in[31:0] = 32'hA5A5A5A5; tick();
        checks++;
        if (countOf(0) !== CW'(1) || doutOf(0) !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL fifo_no_wen: count=%0d dout=%h, required 1 DEADBEEF", countOf(0), doutOf(0));
        end
        wen[0] = 1'b1; data_in[31:0] = 32'hFEED2B0B; tick();
        data_in[31:0] = 32'h00000001; tick();
        wen[0] = 1'b0;
        checks++;
        if (countOf(0) !== CW'(3) || doutOf(0) !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL fifo_three: count=%0d dout=%h, required 3 DEADBEEF", countOf(0), doutOf(0));
        end
        for (int i = 0; i < 3; i++) begin
            ren[0] = 1'b1; tick();
            checks++;
            if (doutOf(0) !== expPop[i]) begin
                errors++; $display("[TB] FAIL fifo_pop%0d: got %h, required %h", i, doutOf(0), expPop[i]);
            end
        end
        ren[0] = 1'b0;
        checks++;
        if (empty[0] !== 1'b1 || unf[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL fifo_drained: empty=%b unf=%b, required 1 0", empty[0], unf[0]);
        end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < DEPTH; i++) begin
            wen[0] = 1'b1; data_in[31:0] = i; tick();
        end
        checks++;
        if (full[0] !== 1'b1 || countOf(0) !== CW'(16)) begin
            errors++; $display("[TB] FAIL full_set: full=%b count=%0d, required 1 16", full[0], countOf(0));
        end
        data_in[31:0] = 32'd99; tick();
        checks++;
        if (ovf[0] !== 1'b1 || countOf(0) !== CW'(16) || doutOf(0) !== 32'd0) begin
            errors++; $display("[TB] FAIL overflow: ovf=%b count=%0d dout=%h, required 1 16 0", ovf[0], countOf(0), doutOf(0));
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (doutOf(0) !== 32'(i)) begin
                errors++; $display("[TB] FAIL wrap_pop%0d: got %0d, required %0d", i, doutOf(0), i);
            end
            wen[0] = 1'b1; ren[0] = 1'b1; data_in[31:0] = 16 + i; tick();
        end
        idle();
        checks++;
        if (countOf(0) !== CW'(16) || doutOf(0) !== 32'd20 || ovf[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL wrap_end: count=%0d dout=%0d ovf=%b, required 16 20 1", countOf(0), doutOf(0), ovf[0]);
        end
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        checks++;
        if (countOf(0) !== CW'(0) || ovf[0] !== 1'b0 || empty[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL clr_after_full: count=%0d ovf=%b empty=%b, required 0 0 1", countOf(0), ovf[0], empty[0]);
        end
    endtask

    task automatic test_replay();
        logic [DATA_W-1:0] expSeq [7];
        expSeq = '{32'd10, 32'd20, 32'd30, 32'd10, 32'd20, 32'd30, 32'd10};
        replay[0] = 1'b1;
        wen[0] = 1'b1;
        data_in[31:0] = 32'd10; tick();
        data_in[31:0] = 32'd20; tick();
        data_in[31:0] = 32'd30; tick();
        wen[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (doutOf(0) !== expSeq[i] || countOf(0) !== CW'(3)) begin
                errors++; $display("[TB] FAIL replay_seq%0d: dout=%0d count=%0d, required %0d 3", i, doutOf(0), countOf(0), expSeq[i]);
            end
            ren[0] = 1'b1; tick();
        end
        checks++;
        if (doutOf(0) !== 32'd20) begin
            errors++; $display("[TB] FAIL replay_after7: got %0d, required 20", doutOf(0));
        end
        rewind[0] = 1'b1; tick(); rewind[0] = 1'b0;
        checks++;
        if (doutOf(0) !== 32'd10 || countOf(0) !== CW'(3)) begin
            errors++; $display("[TB] FAIL rewind: dout=%0d count=%0d, required 10 3", doutOf(0), countOf(0));
        end
        replay[0] = 1'b0; tick();
        ren[0] = 1'b0;
        checks++;
        if (doutOf(0) !== 32'd20 || countOf(0) !== CW'(2)) begin
            errors++; $display("[TB] FAIL replay_to_fifo: dout=%0d count=%0d, required 20 2", doutOf(0), countOf(0));
        end
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    endtask

    task automatic test_underflow_isolation();
        ren[0] = 1'b1; wen[0] = 1'b1; data_in[31:0] = 32'd55;
        wen[1] = 1'b1; data_in[63:32] = 32'h11111111;
        tick();
        idle();
        checks++;
        if (unf[0] !== 1'b1 || countOf(0) !== CW'(1) || doutOf(0) !== 32'd55) begin
            errors++; $display("[TB] FAIL underflow: unf=%b count=%0d dout=%0d, required 1 1 55", unf[0], countOf(0), doutOf(0));
        end
        checks++;
        if (countOf(1) !== CW'(1) || doutOf(1) !== 32'h11111111 || unf[1] !== 1'b0) begin
            errors++; $display("[TB] FAIL ch1_isolated: count=%0d dout=%h unf=%b, required 1 11111111 0", countOf(1), doutOf(1), unf[1]);
        end
        clr[0] = 1'b1; wen[0] = 1'b1; wen[1] = 1'b1; data_in[63:32] = 32'h22222222; tick();
        idle();
        checks++;
        if (countOf(0) !== CW'(0) || unf[0] !== 1'b0 || doutOf(0) !== 32'h0) begin
            errors++; $display("[TB] FAIL clr_unf: count=%0d unf=%b dout=%h, required 0 0 0", countOf(0), unf[0], doutOf(0));
        end
        checks++;
        if (countOf(1) !== CW'(2) || doutOf(1) !== 32'h11111111) begin
            errors++; $display("[TB] FAIL ch1_after_clr0: count=%0d dout=%h, required 2 11111111", countOf(1), doutOf(1));
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 5; i++) begin
            wen[2] = 1'b1; data_in[95:64] = i; tick();
        end
        idle();
        checks++;
        if (countOf(2) !== CW'(5)) begin
            errors++; $display("[TB] FAIL pre_reset_count: got %0d, required 5", countOf(2));
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if (countOf(2) !== CW'(0) || empty[2] !== 1'b1 || doutOf(2) !== 32'h0 || countOf(1) !== CW'(0)) begin
            errors++; $display("[TB] FAIL async_reset: count2=%0d empty2=%b dout2=%h count1=%0d, required 0 1 0 0",
                               countOf(2), empty[2], doutOf(2), countOf(1));
        end
        RST = 1'b0;
        wen[2] = 1'b1; data_in[95:64] = 32'hCAFEF00D; tick();
        idle();
        checks++;
        if (doutOf(2) !== 32'hCAFEF00D || countOf(2) !== CW'(1)) begin
            errors++; $display("[TB] FAIL post_reset_write: dout=%h count=%0d, required CAFEF00D 1", doutOf(2), countOf(2));
        end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_full_wrap();
        test_replay();
        test_underflow_isolation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
